// File: rtl/almacen_arbitro_pkg.sv
// Shared state encoding and default timing for the warehouse carriage arbiter.
package almacen_arbitro_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IDA    = 3'd1,
        CARGA  = 3'd2,
        VUELTA = 3'd3,
        FIN    = 3'd4,
        ERROR  = 3'd5
    } estado_t;

    localparam int T_CARGA_DEF = 8;
    localparam int T_MAX_DEF   = 1000;

endpackage

// File: rtl/almacen_arbitro_sincronizador.sv
// Two-flop synchronizer for asynchronous sensor inputs.
module sincronizador #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/almacen_arbitro.sv
// Round-robin arbiter sharing one carriage between N_EST stations; sequences
// out/load/return with per-move timeout and sensor fault supervision.
module almacen_arbitro
    import almacen_arbitro_pkg::*;
#(
    parameter int N_EST   = 4,
    parameter int T_CARGA = T_CARGA_DEF,
    parameter int T_MAX   = T_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_EST-1:0] req,
    input  logic             S1,
    input  logic             S2,
    input  logic             err_clr,
    output logic             A,
    output logic             R,
    output logic             C,
    output logic [N_EST-1:0] gnt,
    output logic [N_EST-1:0] done,
    output logic             busy,
    output logic             error
);

    localparam int CW = $clog2(T_MAX + 1);
    localparam int IW = (N_EST > 1) ? $clog2(N_EST) : 1;

    estado_t          state_q, state_d;
    logic [CW-1:0]    timer_q, timer_d;
    logic [IW-1:0]    g_q, g_d;
    logic [IW-1:0]    last_q, last_d;
    logic [N_EST-1:0] gnt_q, gnt_d;
    logic [N_EST-1:0] done_q, done_d;
    logic             a_q, a_d, r_q, r_d, c_q, c_d;
    logic             busy_q, busy_d, error_q, error_d;
    logic [1:0]       sens_s;
    logic             s1_s, s2_s, fault, timeout;

    sincronizador #(.W(2)) u_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    ({S1, S2}),
        .q_o    (sens_s)
    );

    assign s1_s = sens_s[1];
    assign s2_s = sens_s[0];

    function automatic logic [N_EST-1:0] onehot(input logic [IW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // Scan farthest-first so the nearest requester after last overwrites the rest.
    function automatic logic [IW-1:0] rr_pick(input logic [N_EST-1:0] r,
                                              input logic [IW-1:0]    last);
        int unsigned idx;
        rr_pick = last;
        for (int unsigned off = N_EST; off >= 1; off--) begin
            idx = (32'(last) + off) % 32'(N_EST);
            if (r[IW'(idx)]) rr_pick = IW'(idx);
        end
    endfunction

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        g_d     = g_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        a_d     = 1'b0;
        r_d     = 1'b0;
        c_d     = 1'b0;
        fault   = s1_s & s2_s;
        timeout = (timer_q == CW'(T_MAX - 1));

        case (state_q)
            IDLE: if (|req) begin
                g_d     = rr_pick(req, last_q);
                gnt_d   = onehot(g_d);
                state_d = IDA;
            end
            IDA: begin
                if (fault)        state_d = ERROR;
                else if (s2_s)    state_d = CARGA;
                else if (timeout) state_d = ERROR;
            end
            CARGA: begin
                if (fault)                state_d = ERROR;
                else if (timer_q == '0)   state_d = VUELTA;
            end
            VUELTA: begin
                if (fault)        state_d = ERROR;
                else if (s1_s)    state_d = FIN;
                else if (timeout) state_d = ERROR;
            end
            FIN: begin
                last_d  = g_q;
                state_d = IDLE;
            end
            ERROR: if (err_clr) begin
                last_d  = g_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            timer_d = (state_d == CARGA) ? CW'(T_CARGA - 1) : '0;
        end else begin
            case (state_q)
                IDA, VUELTA: if (timer_q != '1) timer_d = timer_q + CW'(1);
                CARGA:       if (timer_q != '0) timer_d = timer_q - CW'(1);
                default:     timer_d = timer_q;
            endcase
        end

        // Outputs follow the next state; interlocks keep motors off at an end stop.
        case (state_d)
            IDA:     a_d = ~s2_s;
            CARGA:   c_d = 1'b1;
            VUELTA:  r_d = ~s1_s;
            FIN:     done_d = onehot(g_q);
            default: ;
        endcase
        if (state_d == IDLE || state_d == FIN || state_d == ERROR) gnt_d = '0;
        busy_d  = (state_d != IDLE);
        error_d = (state_d == ERROR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            g_q     <= '0;
            last_q  <= IW'(N_EST - 1);
            gnt_q   <= '0;
            done_q  <= '0;
            a_q     <= 1'b0;
            r_q     <= 1'b0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            g_q     <= g_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            a_q     <= a_d;
            r_q     <= r_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            error_q <= error_d;
        end
    end

    assign A     = a_q;
    assign R     = r_q;
    assign C     = c_q;
    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign error = error_q;

endmodule

// File: tb/tb_almacen_arbitro.sv
// Directed bench for almacen_arbitro: vector table plus multi-cycle sequences.
module tb_almacen_arbitro;

    localparam int TMAX = 1000;

    logic       clk, rst_n, S1, S2, err_clr;
    logic [3:0] req, gnt, done;
    logic       A, R, C, busy, error;

    int checks   = 0;
    int failures = 0;

    almacen_arbitro #(.N_EST(4), .T_CARGA(8), .T_MAX(TMAX)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .S1      (S1),
        .S2      (S2),
        .err_clr (err_clr),
        .A       (A),
        .R       (R),
        .C       (C),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .error   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  req;
        logic        s1;
        logic        s2;
        int          n;
        logic [12:0] exp;
    } vec_t;

    function automatic logic [12:0] mk(input logic a, input logic r, input logic c,
                                       input logic [3:0] g, input logic [3:0] d,
                                       input logic b, input logic e);
        return {a, r, c, g, d, b, e};
    endfunction

    function automatic logic [12:0] outs();
        return {A, R, C, gnt, done, busy, error};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; S1 = 1'b1; S2 = 1'b0; err_clr = 1'b0;
        #12;
        chk("reset_outs", 32'(outs()), 32'd0);
        rst_n = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic run_service(input logic [3:0] exp, input string nm);
        logic bad;
        bad = 1'b0;
        S1 = 1'b0; tick(); tick();
        S2 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (R) break;
            if (gnt !== exp) bad = 1'b1;
            tick();
        end
        chk({nm, "_vuelta"}, 32'(R), 32'd1);
        S2 = 1'b0; tick(); S1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (done != 4'b0) break;
            if (gnt !== exp) bad = 1'b1;
            tick();
        end
        chk({nm, "_done"}, 32'(done), 32'(exp));
        chk({nm, "_gnt_held"}, 32'(bad), 32'd0);
    endtask

    vec_t vt[10];
    int   n_a;

    initial begin
        rst_n = 1'b0; req = '0; S1 = 1'b1; S2 = 1'b0; err_clr = 1'b0;
        do_reset();

        // Single request on station 2 with hand-timed sensor edges.
        vt[0] = '{4'b0000, 1'b1, 1'b0, 3, mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0)};
        vt[1] = '{4'b0100, 1'b1, 1'b0, 1, mk(1, 0, 0, 4'b0100, 4'b0000, 1, 0)};
        vt[2] = '{4'b0100, 1'b0, 1'b0, 9, mk(1, 0, 0, 4'b0100, 4'b0000, 1, 0)};
        vt[3] = '{4'b0100, 1'b0, 1'b1, 2, mk(1, 0, 0, 4'b0100, 4'b0000, 1, 0)};
        vt[4] = '{4'b0100, 1'b0, 1'b1, 8, mk(0, 0, 1, 4'b0100, 4'b0000, 1, 0)};
        vt[5] = '{4'b0100, 1'b0, 1'b1, 1, mk(0, 1, 0, 4'b0100, 4'b0000, 1, 0)};
        vt[6] = '{4'b0100, 1'b0, 1'b0, 3, mk(0, 1, 0, 4'b0100, 4'b0000, 1, 0)};
        vt[7] = '{4'b0100, 1'b1, 1'b0, 2, mk(0, 1, 0, 4'b0100, 4'b0000, 1, 0)};
        vt[8] = '{4'b0100, 1'b1, 1'b0, 1, mk(0, 0, 0, 4'b0000, 4'b0100, 1, 0)};
        vt[9] = '{4'b0000, 1'b1, 1'b0, 2, mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0)};
        for (int v = 0; v < 10; v++) begin
            for (int k = 0; k < vt[v].n; k++) begin
                req = vt[v].req; S1 = vt[v].s1; S2 = vt[v].s2;
                tick();
                chk($sformatf("vec%0d_%0d", v, k), 32'(outs()), 32'(vt[v].exp));
            end
        end

        // Round-robin from reset pointer: 0,1,2,3 then wrap to 0.
        do_reset();
        req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            logic [3:0] eg;
            eg = 4'b0001 << (s % 4);
            tick();
            chk($sformatf("rr%0d_start", s), 32'(outs()), 32'(mk(1, 0, 0, eg, 4'b0000, 1, 0)));
            run_service(eg, $sformatf("rr%0d", s));
            if (s == 4) req = '0;
            tick();
            chk($sformatf("rr%0d_idle", s), 32'(outs()), 32'd0);
        end

        // Timeout on station 0, then err_clr hands the turn onward.
        S1 = 1'b0; req = 4'b0001;
        tick();
        n_a = 0;
        for (int i = 0; i < 2 * TMAX; i++) begin
            if (!A) break;
            n_a++;
            tick();
        end
        chk("timeout_a_cycles", 32'(n_a), 32'(TMAX));
        chk("timeout_err", 32'(outs()), 32'(mk(0, 0, 0, 4'b0000, 4'b0000, 1, 1)));
        tick(); tick(); tick();
        chk("err_hold", 32'(outs()), 32'(mk(0, 0, 0, 4'b0000, 4'b0000, 1, 1)));
        req = 4'b0011; err_clr = 1'b1;
        tick();
        chk("err_clr_idle", 32'(outs()), 32'd0);
        err_clr = 1'b0;
        tick();
        chk("after_err_gnt", 32'(outs()), 32'(mk(1, 0, 0, 4'b0010, 4'b0000, 1, 0)));

        // Both sensors high during IDA: fault three edges later, no done.
        S1 = 1'b1; S2 = 1'b1;
        tick(); tick();
        chk("fault_pre", 32'(outs()), 32'(mk(1, 0, 0, 4'b0010, 4'b0000, 1, 0)));
        tick();
        chk("fault_err", 32'(outs()), 32'(mk(0, 0, 0, 4'b0000, 4'b0000, 1, 1)));
        tick();
        chk("fault_nodone", 32'(outs()), 32'(mk(0, 0, 0, 4'b0000, 4'b0000, 1, 1)));
        S2 = 1'b0; req = '0; err_clr = 1'b1;
        tick();
        chk("fault_clr", 32'(outs()), 32'd0);
        err_clr = 1'b0;
        tick(); tick(); tick();

        // Asynchronous reset in CARGA, then pointer restarts at station 0.
        req = 4'b0100;
        tick();
        chk("rst_ida", 32'(outs()), 32'(mk(1, 0, 0, 4'b0100, 4'b0000, 1, 0)));
        S1 = 1'b0; tick(); S2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (C) break;
            tick();
        end
        chk("rst_carga", 32'(C), 32'd1);
        tick(); tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 32'(outs()), 32'd0);
        req = 4'b1000; S2 = 1'b0; S1 = 1'b1;
        tick(); tick();
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst_gnt", 32'(outs()), 32'(mk(1, 0, 0, 4'b1000, 4'b0000, 1, 0)));
        run_service(4'b1000, "post_rst");
        req = '0;
        tick();
        chk("post_rst_idle", 32'(outs()), 32'd0);

        // Granted station drops req and another raises it mid-service.
        req = 4'b0010;
        tick();
        chk("wd_start", 32'(outs()), 32'(mk(1, 0, 0, 4'b0010, 4'b0000, 1, 0)));
        req = 4'b0001;
        run_service(4'b0010, "wd");
        req = '0;
        tick();
        chk("wd_idle", 32'(outs()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
